phy_rx_lane_merge: RTL and testbench
====================================

// Module: phy_rx_lane_merge
// PURPOSE
//  Receive side of the 2-lane PHY link. Takes the two 8-bit byte lanes produced
//  by the TX lane splitter and reassembles them into 32-bit words.
//  Each word arrives over two beats, with both lanes valid in lockstep.
//  Checks lane alignment and inter-beat gap, and counts good words for the link monitor.
// PARAMETERS
//  MAX_GAP  4   max idle cycles allowed between beat 0 and beat 1 of a word (1..15)
//  CNT_W    16  width of word_count
// PORTS
//  clk_4f       in   1      single block clock; all logic on posedge
//  reset        in   1      synchronous, active-low reset (0 = reset)
//  data_in_0    in   8      lane 0 byte
//  data_in_1    in   8      lane 1 byte
//  valid_in_0   in   1      lane 0 byte valid
//  valid_in_1   in   1      lane 1 byte valid
//  data_out     out  32     reassembled word; held until next word completes
//  valid_out    out  1      one-cycle pulse: data_out is a new word
//  err_lane     out  1      sticky: lane valids disagreed
//  err_timeout  out  1      one-cycle pulse: partial word discarded on gap timeout
//  word_count   out  CNT_W  count of good words, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - data_out=0, valid_out=0, err_lane=0, err_timeout=0, word_count=0.
//   - FSM goes to WAIT_HI, gap counter=0.
//   - Reset overrides everything, including mid-word; any partial word is lost.
//  Beat = cycle with valid_in_0 && valid_in_1.
//   - Byte order: beat0 {lane0,lane1} -> data[31:16]; beat1 {lane0,lane1} -> data[15:0].
//  FSM WAIT_HI:
//   - Beat: latch hi_half = {data_in_0,data_in_1}, gap=0, go to WAIT_LO.
//   - No valids: stay.
//  FSM WAIT_LO:
//   - Beat: registered at the same edge:
//     - data_out <= {hi_half, data_in_0, data_in_1}
//     - valid_out <= 1
//     - word_count <= word_count+1
//     - go to WAIT_HI
//   - Latency: valid_out is high in the cycle after beat1 is sampled.
//   - Back-to-back words are supported at 1 word / 2 cycles, no bubble.
//   - No valids: gap <= gap+1.
//     - If gap==MAX_GAP-1, the partial word is dropped instead: err_timeout pulses next cycle, go to WAIT_HI.
//     - So MAX_GAP idle cycles are tolerated only if fewer than MAX_GAP;
//       the MAX_GAP-th consecutive idle cycle triggers the timeout.
//  Lane mismatch (valid_in_0 != valid_in_1), any state:
//   - err_lane <= 1 (sticky until reset); the cycle's data is ignored.
//   - In WAIT_LO the partial word is discarded, go to WAIT_HI, no err_timeout.
//  Priority in the same cycle: reset > mismatch > beat > gap/timeout.
//  valid_out and err_timeout default to 0 in every cycle not named above.
//  word_count increments only on valid_out; wraps from all-ones to 0 with no flag.
//  data_out is not cleared by errors; it keeps the last good word.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles with random lane data -> all outputs 0, no valid_out.
//  2 Single word:
//    - Stimulus: beats {AB,CD} then {12,34}.
//    - Response: valid_out pulses once, 1 cycle after beat1, data_out=32'hABCD1234, word_count=1.
//  3 Back-to-back: 4 words over 8 consecutive beats, 32'h00000001..32'h00000004
//    -> valid_out every 2nd cycle, values in order, word_count=4.
//  4 Gap:
//    - Beat0 32'hDEAD.., then 3 idle cycles, then beat1 -> 32'hDEADBEEF delivered.
//    - Beat0, then 4 idle cycles -> err_timeout pulses once, no valid_out, next word clean.
//  5 Mismatch:
//    - Stimulus: valid_in_0=1, valid_in_1=0 after beat0.
//    - Response: err_lane=1 and stays high; partial dropped.
//    - Following word 32'hCAFEF00D is received correctly.
//  6 Wrap and reset mid-word:
//    - Preload via 2^CNT_W words (or force CNT_W=4 and send 16 words) -> word_count wraps to 0.
//    - Assert reset between beat0 and beat1 -> no valid_out.
//    - The next two beats form a fresh word.

Source files
------------

// File: rtl/phy_rx_lane_merge.sv
// phy_rx_lane_merge: reassemble two 8-bit PHY lanes into 32-bit words, checking lane alignment and beat gap
// Ports:
//   clk_4f      single clock, posedge
//   reset       synchronous, active-low
//   data_in_0/1 lane bytes; valid_in_0/1 lane valids (beat = both high)
//   data_out    last good word, held; valid_out one-cycle new-word pulse
//   err_lane    sticky lane-valid disagreement; err_timeout one-cycle partial-word drop pulse
//   word_count  good words, wraps modulo 2^CNT_W
module phy_rx_lane_merge #(
  parameter int MAX_GAP = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [7:0]       data_in_0,
  input  logic [7:0]       data_in_1,
  input  logic             valid_in_0,
  input  logic             valid_in_1,
  output logic [31:0]      data_out,
  output logic             valid_out,
  output logic             err_lane,
  output logic             err_timeout,
  output logic [CNT_W-1:0] word_count
);
  typedef enum logic {WAIT_HI, WAIT_LO} state_t;
  state_t             state, state_n;
  logic [15:0]        hi_half, hi_n;
  logic [3:0]         gap, gap_n;
  logic [31:0]        data_n;
  logic               vout_n, tout_n, elane_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               beat, mism;
  assign beat = valid_in_0 & valid_in_1;
  assign mism = valid_in_0 ^ valid_in_1;
  always_comb begin
    state_n = state;
    hi_n    = hi_half;
    gap_n   = gap;
    data_n  = data_out;
    vout_n  = 1'b0;
    tout_n  = 1'b0;
    elane_n = err_lane | mism;
    cnt_n   = word_count;
    if (mism) begin
      state_n = WAIT_HI;
    end else if (beat) begin
      if (state == WAIT_HI) begin
        hi_n    = {data_in_0, data_in_1};
        gap_n   = 4'd0;
        state_n = WAIT_LO;
      end else begin
        data_n  = {hi_half, data_in_0, data_in_1};
        vout_n  = 1'b1;
        cnt_n   = word_count + 1'b1;
        state_n = WAIT_HI;
      end
    end else if (state == WAIT_LO) begin
      gap_n = gap + 4'd1;
      // the MAX_GAP-th consecutive idle cycle drops the partial word
      if (gap == 4'(MAX_GAP - 1)) begin
        tout_n  = 1'b1;
        state_n = WAIT_HI;
      end
    end
  end
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state       <= WAIT_HI;
      hi_half     <= '0;
      gap         <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      err_timeout <= 1'b0;
      err_lane    <= 1'b0;
      word_count  <= '0;
    end else begin
      state       <= state_n;
      hi_half     <= hi_n;
      gap         <= gap_n;
      data_out    <= data_n;
      valid_out   <= vout_n;
      err_timeout <= tout_n;
      err_lane    <= elane_n;
      word_count  <= cnt_n;
    end
  end
endmodule

// File: tb/tb_phy_rx_lane_merge.sv
// tb_phy_rx_lane_merge: scoreboard bench for phy_rx_lane_merge (CNT_W=4 to reach the wrap quickly)
module tb_phy_rx_lane_merge;
  logic        clk_4f = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in_0 = '0, data_in_1 = '0;
  logic        valid_in_0 = 1'b0, valid_in_1 = 1'b0;
  logic [31:0] data_out;
  logic        valid_out, err_lane, err_timeout;
  logic [3:0]  word_count;
  typedef struct {
    bit          to;
    logic [31:0] data;
    logic [3:0]  cnt;
  } exp_t;
  exp_t       q[$];
  int         checks = 0, errors = 0;
  logic [3:0] exp_cnt = '0;
  phy_rx_lane_merge #(.MAX_GAP(4), .CNT_W(4)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .valid_in_0(valid_in_0), .valid_in_1(valid_in_1),
    .data_out(data_out), .valid_out(valid_out),
    .err_lane(err_lane), .err_timeout(err_timeout),
    .word_count(word_count)
  );
  always #5 clk_4f = ~clk_4f;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  always @(negedge clk_4f) begin
    if (valid_out === 1'b1 || err_timeout === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got valid_out=%b err_timeout=%b expected none", valid_out, err_timeout);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("event_kind", {30'd0, valid_out, err_timeout}, e.to ? 32'd1 : 32'd2);
        if (!e.to) begin
          check("data_out", data_out, e.data);
          check("word_count", {28'd0, word_count}, {28'd0, e.cnt});
        end
      end
    end
  end
  task automatic cyc(input logic v0, input logic v1, input logic [7:0] d0, input logic [7:0] d1);
    valid_in_0 = v0;
    valid_in_1 = v1;
    data_in_0  = d0;
    data_in_1  = d1;
    @(posedge clk_4f);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00);
  endtask
  task automatic push_word(input logic [31:0] w);
    exp_t e;
    exp_cnt = exp_cnt + 4'd1;
    e.to = 1'b0;
    e.data = w;
    e.cnt = exp_cnt;
    q.push_back(e);
  endtask
  task automatic word(input logic [31:0] w);
    cyc(1'b1, 1'b1, w[31:24], w[23:16]);
    push_word(w);
    cyc(1'b1, 1'b1, w[15:8], w[7:0]);
  endtask
  initial begin
    exp_t t;
    // reset with random lane activity
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    check("rst_data_out", data_out, 32'd0);
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_err_lane", {31'd0, err_lane}, 32'd0);
    check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    check("rst_word_count", {28'd0, word_count}, 32'd0);
    reset = 1'b1;
    idle(1);
    // single word
    word(32'hABCD1234);
    idle(3);
    check("held_data_out", data_out, 32'hABCD1234);
    // back-to-back words
    for (int i = 1; i <= 4; i++) word(32'(i));
    idle(2);
    check("b2b_word_count", {28'd0, word_count}, 32'd5);
    // gap of 3 idle cycles tolerated
    cyc(1'b1, 1'b1, 8'hDE, 8'hAD);
    idle(3);
    push_word(32'hDEADBEEF);
    cyc(1'b1, 1'b1, 8'hBE, 8'hEF);
    idle(2);
    // gap of 4 idle cycles times out
    cyc(1'b1, 1'b1, 8'h55, 8'h66);
    idle(3);
    t.to = 1'b1;
    t.data = '0;
    t.cnt = '0;
    q.push_back(t);
    idle(3);
    check("to_data_kept", data_out, 32'hDEADBEEF);
    word(32'h01020304);
    idle(2);
    // lane mismatch after beat0
    check("pre_err_lane", {31'd0, err_lane}, 32'd0);
    cyc(1'b1, 1'b1, 8'h11, 8'h22);
    cyc(1'b1, 1'b0, 8'h33, 8'h44);
    check("mism_err_lane", {31'd0, err_lane}, 32'd1);
    word(32'hCAFEF00D);
    idle(6);
    check("sticky_err_lane", {31'd0, err_lane}, 32'd1);
    // wrap the 4-bit counter to 0
    while (exp_cnt != 4'd0) word(32'h100 + 32'(exp_cnt));
    idle(2);
    check("wrap_word_count", {28'd0, word_count}, 32'd0);
    // reset between beat0 and beat1
    cyc(1'b1, 1'b1, 8'h77, 8'h88);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    exp_cnt = '0;
    check("mid_rst_data_out", data_out, 32'd0);
    check("mid_rst_err_lane", {31'd0, err_lane}, 32'd0);
    word(32'h99AABBCC);
    idle(3);
    check("final_word_count", {28'd0, word_count}, 32'd1);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
